// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter that shares one single-ported ram between two masters.
// Latency: ram_stb rises one cycle after the winning mN_stb is sampled; ack/err are returned combinationally.
// Backpressure: a master holds mN_stb until its mN_ack/mN_err; the losing master simply waits, and a watchdog aborts a stuck access.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   mN_stb/we/addr/data_in     request from master N (0 = CPU, 1 = display/DMA refill)
//   mN_data_out/ack/err        read data, completion pulse and timeout pulse to master N
//   ram_stb/we/addr/data_out   registered request to the ram
//   ram_data_in, ram_ack       read data and completion pulse from the ram
module ram_arb #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data_in,
  output logic [DATA_W-1:0] m0_data_out,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data_in,
  output logic [DATA_W-1:0] m1_data_out,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              ram_stb,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic              ram_ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Last timer value before the watchdog fires.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       gnt;     // master currently owning the ram
  logic       last;    // master granted most recently
  logic [7:0] timer;   // cycles spent in BUSY without ram_ack
  logic       pick;    // master that wins arbitration this cycle
  logic       done;    // ram completed the access this cycle
  logic       tmo;     // watchdog abort this cycle

  // On a tie the master that was not served last wins.
  assign pick = (m0_stb && m1_stb) ? ~last : m1_stb;

  // ram_ack has priority over the watchdog when both land in the same cycle.
  assign done = (state == BUSY) && ram_ack;
  assign tmo  = (state == BUSY) && !ram_ack && (timer == TMO_LAST);

  assign m0_ack = done && !gnt;
  assign m1_ack = done &&  gnt;
  assign m0_err = tmo  && !gnt;
  assign m1_err = tmo  &&  gnt;

  // Read data is passed through unconditionally; only the ack cycle is meaningful.
  assign m0_data_out = ram_data_in;
  assign m1_data_out = ram_data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      last         <= 1'b1;
      timer        <= 8'd0;
      ram_stb      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_stb || m1_stb) begin
            gnt          <= pick;
            last         <= pick;
            ram_we       <= pick ? m1_we      : m0_we;
            ram_addr     <= pick ? m1_addr    : m0_addr;
            ram_data_out <= pick ? m1_data_in : m0_data_in;
            ram_stb      <= 1'b1;
            timer        <= 8'd0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (done || tmo) begin
            // Always return to IDLE for at least one cycle between accesses.
            ram_stb <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

  localparam int TMO = 16;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [31:0] data;
  } op_t;

  logic        clk, rst;
  logic [1:0]  stb, we, ack, err;
  logic [21:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] dout [2];
  logic        ram_stb, ram_we, ram_ack;
  logic [21:0] ram_addr;
  logic [31:0] ram_data_out, ram_rdata;

  ram_arb #(.ADDR_W(22), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(stb[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_data_in(wdat[0]),
    .m0_data_out(dout[0]), .m0_ack(ack[0]), .m0_err(err[0]),
    .m1_stb(stb[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_data_in(wdat[1]),
    .m1_data_out(dout[1]), .m1_ack(ack[1]), .m1_err(err[1]),
    .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_data_in(ram_rdata), .ram_ack(ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench state: master request queues, ram behaviour and reference bookkeeping.
  op_t         q0[$], q1[$];
  op_t         cur [2];
  bit          act [2], done_prev [2];
  int          raise_t [2], prev_len [2], a_ack [2], a_err [2];
  logic [31:0] mem [int];
  logic [31:0] gold [int];
  int          ram_lat, rcnt, gate_pct, tick_n, bcnt, g, last_g, err_at;
  bit          spur, rand_lat, prev_busy, prev_end;
  logic [1:0]  prev_pend;
  logic [54:0] held;
  logic [31:0] last_rd;
  int          gl[$];
  int          n_chk, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_state();
    stb = 2'b00; ram_ack = 1'b0; spur = 0; rcnt = 0;
    q0.delete(); q1.delete();
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; done_prev[n] = 0; prev_len[n] = 0;
    end
    prev_busy = 0; prev_end = 0; prev_pend = 2'b00; last_g = 1; bcnt = 0;
  endtask

  function automatic op_t mk(input logic w, input logic [21:0] a, input logic [31:0] d);
    op_t o;
    o.we = w; o.addr = a; o.data = d;
    return o;
  endfunction

  task automatic load(input int n);
    act[n] = 1; stb[n] = 1'b1; raise_t[n] = tick_n;
    we[n] = cur[n].we; addr[n] = cur[n].addr; wdat[n] = cur[n].data;
  endtask

  // Reference checks at the sample point of each cycle.
  task automatic sample();
    bit e_ack, e_err;
    int w;
    if (!prev_busy) begin
      check("stb_start", ram_stb, prev_pend != 2'b00);
      if (ram_stb) begin
        g = (prev_pend == 2'b11) ? 1 - last_g : (prev_pend[1] ? 1 : 0);
        last_g = g;
        gl.push_back(g);
        bcnt = 0;
        check("grant_we", ram_we, cur[g].we);
        check("grant_addr", ram_addr, cur[g].addr);
        check("grant_data", ram_data_out, cur[g].data);
        w = tick_n - raise_t[g];
        check("wait_bound", w <= prev_len[1-g] + 2, 1);
        held = {ram_we, ram_addr, ram_data_out};
      end
    end else if (prev_end) begin
      check("stb_fall", ram_stb, 0);
    end else begin
      check("stb_hold", ram_stb, 1);
      check("req_hold", {ram_we, ram_addr, ram_data_out}, held);
    end
    if (ram_stb) bcnt++;
    e_ack = ram_stb && ram_ack;
    e_err = ram_stb && !ram_ack && (bcnt == TMO);
    for (int n = 0; n < 2; n++) begin
      check(n == 0 ? "m0_ack" : "m1_ack", ack[n], e_ack && g == n);
      check(n == 0 ? "m0_err" : "m1_err", err[n], e_err && g == n);
      if (ack[n]) a_ack[n]++;
      if (err[n]) begin a_err[n]++; err_at = bcnt; end
    end
    if (e_ack) begin
      if (cur[g].we) gold[int'(cur[g].addr)] = cur[g].data;
      else begin
        last_rd = dout[g];
        check("rdata", dout[g], gold.exists(int'(cur[g].addr)) ? gold[int'(cur[g].addr)] : 32'h0);
      end
    end
    if (e_ack || e_err) begin done_prev[g] = 1; prev_len[g] = bcnt; end
    prev_end = e_ack || e_err;
    prev_busy = ram_stb;
    prev_pend = stb;
  endtask

  task automatic tick();
    @(negedge clk);
    tick_n++;
    for (int n = 0; n < 2; n++) begin
      if (done_prev[n]) begin
        act[n] = 0; done_prev[n] = 0; stb[n] = 1'b0;
        addr[n] = 22'($urandom); wdat[n] = $urandom; we[n] = 1'($urandom);
      end else if (!act[n] && $urandom_range(99) < gate_pct) begin
        if (n == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); load(0); end
        if (n == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); load(1); end
      end
    end
    // ram behaviour: acks after ram_lat cycles of stb (0 = never)
    if (spur) begin
      ram_ack = 1'b1; spur = 0;
    end else if (!ram_stb) begin
      rcnt = 0; ram_ack = 1'b0; ram_rdata = $urandom;
    end else if (ram_ack) begin
      ram_ack = 1'b0;
    end else begin
      if (rcnt == 0 && rand_lat) ram_lat = $urandom_range(1, 20);
      rcnt++;
      ram_rdata = $urandom;
      if (rcnt == ram_lat) begin
        ram_ack = 1'b1;
        if (ram_we) mem[int'(ram_addr)] = ram_data_out;
        else ram_rdata = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
      end
    end
    #1;
    sample();
  endtask

  task automatic run(input int maxc);
    int c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || ram_stb) && c < maxc) begin
      tick(); c++;
    end
    check("drain", c < maxc, 1);
    tick(); tick();
  endtask

  task automatic zero_counts();
    for (int n = 0; n < 2; n++) begin a_ack[n] = 0; a_err[n] = 0; end
    gl.delete();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    clr_state();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; tick_n = 0; gate_pct = 100; rand_lat = 0; ram_lat = 3;
    we = 2'b00; ram_rdata = 32'h0; err_at = 0; last_rd = 32'h0; held = '0;
    for (int n = 0; n < 2; n++) begin addr[n] = '0; wdat[n] = '0; raise_t[n] = 0; end
    clr_state();
    zero_counts();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_stb", ram_stb, 0);
    check("rst_req", {ram_we, ram_addr, ram_data_out}, 0);
    check("rst_ack_err", {ack, err}, 0);
    rst = 1'b0;

    // 1: single m0 read, ram answers in 3 cycles
    mem[32'h1000] = 32'h44444444; gold[32'h1000] = 32'h44444444;
    ram_lat = 3;
    q0.push_back(mk(1'b0, 22'h1000, 32'h0));
    run(100);
    check("t1_rd", last_rd, 32'h44444444);
    check("t1_m0_acks", a_ack[0], 1);
    check("t1_m1_acks", a_ack[1], 0);

    // 2: simultaneous writes to the same address after a fresh reset
    pulse_rst();
    zero_counts();
    q0.push_back(mk(1'b1, 22'h1000, 32'h55555555));
    q1.push_back(mk(1'b1, 22'h1000, 32'h66666666));
    run(100);
    check("t2_grants", gl.size(), 2);
    if (gl.size() == 2) begin
      check("t2_first", gl[0], 0);
      check("t2_second", gl[1], 1);
    end
    q0.push_back(mk(1'b0, 22'h1000, 32'h0));
    run(100);
    check("t2_rd", last_rd, 32'h66666666);

    // 3: continuous requests from both masters
    zero_counts();
    rand_lat = 1; 
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'($urandom), 22'(i), $urandom));
      q1.push_back(mk(1'($urandom), 22'(i + 8), $urandom));
    end
    rand_lat = 0; ram_lat = 1 + (tick_n % 4);
    run(400);
    check("t3_grants", gl.size(), 8);
    for (int i = 1; i < gl.size(); i++) check("t3_alternate", gl[i], 1 - gl[i-1]);

    // 4: ram never acks an m1 read; then m0 is served normally
    zero_counts();
    ram_lat = 0; err_at = 0;
    q1.push_back(mk(1'b0, 22'h2000, 32'h0));
    run(100);
    check("t4_m1_err", a_err[1], 1);
    check("t4_err_at", err_at, TMO);
    check("t4_m1_ack", a_ack[1], 0);
    ram_lat = 2;
    q0.push_back(mk(1'b1, 22'h2000, 32'hA5A5A5A5));
    run(100);
    check("t4_m0_ack", a_ack[0], 1);

    // 5: ack lands in the last cycle before the watchdog
    zero_counts();
    ram_lat = TMO;
    q0.push_back(mk(1'b0, 22'h2000, 32'h0));
    run(100);
    check("t5_ack", a_ack[0], 1);
    check("t5_err", a_err[0], 0);
    check("t5_rd", last_rd, 32'hA5A5A5A5);

    // 6: reset in the middle of an access, then a tie and a spurious ack
    ram_lat = 0;
    q0.push_back(mk(1'b0, 22'h3000, 32'h0));
    for (int c = 0; c < 20 && !ram_stb; c++) tick();
    check("t6_busy", ram_stb, 1);
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_stb", ram_stb, 0);
    check("t6_rst_ack_err", {ack, err}, 0);
    check("t6_rst_addr", ram_addr, 0);
    clr_state();
    @(negedge clk);
    rst = 1'b0;
    zero_counts();
    spur = 1;
    tick(); tick();
    check("t6_spur_ack", a_ack[0] + a_ack[1], 0);
    ram_lat = 2;
    q0.push_back(mk(1'b1, 22'h3000, 32'h01234567));
    q1.push_back(mk(1'b1, 22'h3001, 32'h89ABCDEF));
    run(100);
    check("t6_tie_first", gl.size() > 0 ? gl[0] : -1, 0);

    // 7: randomized traffic with varying ram latency (some accesses time out)
    zero_counts();
    rand_lat = 1; gate_pct = 30;
    for (int i = 0; i < 24; i++) begin
      q0.push_back(mk(1'($urandom), 22'($urandom_range(0, 7)), $urandom));
      q1.push_back(mk(1'($urandom), 22'($urandom_range(0, 7)), $urandom));
    end
    run(5000);
    check("t7_total", a_ack[0] + a_ack[1] + a_err[0] + a_err[1], 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
